// File: rtl/spi_adc_pkg.sv
// rtl/spi_adc_pkg.sv - shared defaults, output phase type and clog2 helper for the SPI ADC slave
package spi_adc_pkg;

  localparam int DEF_DATA_W     = 12;
  localparam int DEF_N_CH       = 8;
  localparam int DEF_CH_W       = 3;
  localparam int DEF_FRAME_LEN  = 16;
  localparam int DEF_LEAD_ZEROS = 4;
  localparam int DEF_ADDR_POS   = 2;

  typedef enum logic [1:0] {
    PH_OFF,
    PH_ZERO,
    PH_DATA
  } sdata_phase_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_slave_adc_mc_if.sv
// rtl/spi_slave_adc_mc_if.sv - frame control, channel inputs and status of the SPI ADC slave
interface spi_slave_adc_mc_if #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 12,
  parameter int CH_W   = 3
);
  logic                     cs_n;
  logic                     din;
  logic [N_CH*DATA_W-1:0]   ch_data;
  logic [CH_W-1:0]          cur_ch;
  logic                     sdata_oe;

  modport master (output cs_n, output din, output ch_data, input cur_ch, input sdata_oe);
  modport slave  (input cs_n, input din, input ch_data, output cur_ch, output sdata_oe);
endinterface

// File: rtl/spi_adc_shreg.sv
// rtl/spi_adc_shreg.sv - negedge load/shift register presenting its MSB, async cleared
module spi_adc_shreg #(
  parameter int W = 12
) (
  input  logic         i_sclk,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_d,
  output logic         o_msb
);
  logic [W-1:0] r_q;

  always_ff @(negedge i_sclk or posedge i_clr) begin
    if (i_clr) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_shift) begin
      r_q <= r_q << 1;
    end
  end

  assign o_msb = r_q[W-1];
endmodule

// File: rtl/spi_slave_adc_mc.sv
// rtl/spi_slave_adc_mc.sv - multi-channel SPI ADC slave: zero-framed samples, channel
// address on din takes effect from the following frame
module spi_slave_adc_mc
  import spi_adc_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int N_CH       = DEF_N_CH,
  parameter int CH_W       = DEF_CH_W,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int LEAD_ZEROS = DEF_LEAD_ZEROS,
  parameter int ADDR_POS   = DEF_ADDR_POS
) (
  input  logic              i_sclk,
  input  logic              i_n_rst,
  spi_slave_adc_mc_if.slave bus,
  output wire               o_sdata
);
  localparam int CNT_W = clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] C_FRAME   = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] C_LOAD    = CNT_W'(LEAD_ZEROS - 1);
  localparam logic [CNT_W-1:0] C_DATA_LO = CNT_W'(LEAD_ZEROS);
  localparam logic [CNT_W-1:0] C_DATA_HI = CNT_W'(LEAD_ZEROS + DATA_W);
  localparam logic [CNT_W-1:0] C_ADDR_LO = CNT_W'(ADDR_POS);
  localparam logic [CNT_W-1:0] C_ADDR_HI = CNT_W'(ADDR_POS + CH_W);
  localparam logic [CH_W:0]    C_NCH     = (CH_W + 1)'(N_CH);

  logic [CNT_W-1:0]  r_cnt;
  logic [CH_W-1:0]   r_addr_sh;
  logic [CH_W-1:0]   r_ch_sel;
  logic              w_frame_clr;
  logic              w_load;
  logic              w_shift;
  logic              w_msb;
  logic [DATA_W-1:0] w_sample;
  sdata_phase_e      w_phase;

  // cs_n high aborts the frame immediately; the selected channel survives it
  assign w_frame_clr = !i_n_rst || bus.cs_n;

  always_ff @(negedge i_sclk or posedge w_frame_clr) begin
    if (w_frame_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != C_FRAME) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_sclk or posedge w_frame_clr) begin
    if (w_frame_clr) begin
      r_addr_sh <= '0;
    end else if (r_cnt >= C_ADDR_LO && r_cnt < C_ADDR_HI) begin
      r_addr_sh <= CH_W'({r_addr_sh, bus.din});
    end
  end

  // out-of-range addresses are ignored so the mux never selects a missing channel
  always_ff @(negedge i_sclk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_ch_sel <= '0;
    end else if (!bus.cs_n && r_cnt == C_LAST && {1'b0, r_addr_sh} < C_NCH) begin
      r_ch_sel <= r_addr_sh;
    end
  end

  assign w_sample = bus.ch_data[int'(r_ch_sel)*DATA_W +: DATA_W];
  assign w_load   = (r_cnt == C_LOAD);
  assign w_shift  = (r_cnt >= C_DATA_LO) && (r_cnt < C_FRAME);

  spi_adc_shreg #(
    .W(DATA_W)
  ) u_shreg (
    .i_sclk  (i_sclk),
    .i_clr   (w_frame_clr),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_d     (w_sample),
    .o_msb   (w_msb)
  );

  always_comb begin
    w_phase = PH_ZERO;
    if (bus.cs_n || r_cnt >= C_FRAME) begin
      w_phase = PH_OFF;
    end else if (r_cnt >= C_DATA_LO && r_cnt < C_DATA_HI) begin
      w_phase = PH_DATA;
    end
  end

  assign bus.sdata_oe = (w_phase != PH_OFF);
  assign bus.cur_ch   = r_ch_sel;
  assign o_sdata      = bus.sdata_oe ? ((w_phase == PH_DATA) ? w_msb : 1'b0) : 1'bz;
endmodule

// File: tb/tb_spi_slave_adc_mc.sv
// tb/tb_spi_slave_adc_mc.sv - bench for spi_slave_adc_mc with an 8-channel and a 6-channel instance
module tb_spi_slave_adc_mc;
  localparam int DW = 12;
  localparam int FL = 16;
  localparam int LZ = 4;
  localparam int AP = 2;
  localparam int CW = 3;

  logic          sclk;
  logic          n_rst;
  logic          cs_n;
  logic          din;
  logic [8*DW-1:0] ch_data;
  wire           sd0;
  wire           sd1;

  spi_slave_adc_mc_if #(.N_CH(8), .DATA_W(DW), .CH_W(CW)) bus0 ();
  spi_slave_adc_mc_if #(.N_CH(6), .DATA_W(DW), .CH_W(CW)) bus1 ();

  assign bus0.cs_n    = cs_n;
  assign bus0.din     = din;
  assign bus0.ch_data = ch_data;
  assign bus1.cs_n    = cs_n;
  assign bus1.din     = din;
  assign bus1.ch_data = ch_data[6*DW-1:0];

  spi_slave_adc_mc #(
    .DATA_W(DW), .N_CH(8), .CH_W(CW), .FRAME_LEN(FL), .LEAD_ZEROS(LZ), .ADDR_POS(AP)
  ) dut0 (
    .i_sclk(sclk), .i_n_rst(n_rst), .bus(bus0.slave), .o_sdata(sd0)
  );

  spi_slave_adc_mc #(
    .DATA_W(DW), .N_CH(6), .CH_W(CW), .FRAME_LEN(FL), .LEAD_ZEROS(LZ), .ADDR_POS(AP)
  ) dut1 (
    .i_sclk(sclk), .i_n_rst(n_rst), .bus(bus1.slave), .o_sdata(sd1)
  );

  // model: frame position, captured sample value, address value, selected channel
  int   m_cnt;
  int   m_addr;
  int   m_ch[2];
  int   m_sample[2];
  int   n_tests;
  int   n_fail;
  event e_chk;

  function automatic int nch(input int d);
    return (d == 0) ? 8 : 6;
  endfunction

  function automatic int chan_val(input int c);
    return int'(ch_data[c*DW +: DW]);
  endfunction

  function automatic int exp_bit(input int d);
    if (m_cnt >= LZ && m_cnt < LZ + DW)
      return (m_sample[d] >> (DW - 1 - (m_cnt - LZ))) & 1;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int act_oe;
    int act_sd;
    int act_ch;
    int exp_oe;
    forever begin
      @(e_chk);
      for (int d = 0; d < 2; d++) begin
        act_oe = (d == 0) ? int'(bus0.sdata_oe) : int'(bus1.sdata_oe);
        act_sd = (d == 0) ? int'(sd0) : int'(sd1);
        act_ch = (d == 0) ? int'(bus0.cur_ch) : int'(bus1.cur_ch);
        exp_oe = (!cs_n && m_cnt < FL) ? 1 : 0;
        chk((d == 0) ? "oe8" : "oe6", act_oe, exp_oe);
        if (exp_oe == 1 && act_oe == 1)
          chk((d == 0) ? "sdata8" : "sdata6", act_sd, exp_bit(d));
        chk((d == 0) ? "cur_ch8" : "cur_ch6", act_ch, m_ch[d]);
      end
    end
  end

  task automatic neg_step();
    sclk = 1'b0;
    #1;
    if (!cs_n && n_rst) begin
      for (int d = 0; d < 2; d++) begin
        if (m_cnt == LZ - 1) m_sample[d] = chan_val(m_ch[d]);
        if (m_cnt == FL - 1 && m_addr < nch(d)) m_ch[d] = m_addr;
      end
      if (m_cnt < FL) m_cnt++;
    end
    ->e_chk;
    #4;
  endtask

  task automatic pos_step();
    sclk = 1'b1;
    #1;
    if (!cs_n && n_rst && m_cnt >= AP && m_cnt < AP + CW)
      m_addr = ((m_addr << 1) | int'(din)) & ((1 << CW) - 1);
    ->e_chk;
    #4;
  endtask

  task automatic set_cs(input logic v);
    cs_n = v;
    #1;
    if (v) begin
      m_cnt = 0;
      m_addr = 0;
      m_sample[0] = 0;
      m_sample[1] = 0;
    end
    ->e_chk;
    #4;
  endtask

  task automatic set_rst(input logic v);
    n_rst = v;
    #1;
    if (!v) begin
      m_cnt = 0;
      m_addr = 0;
      m_sample[0] = 0;
      m_sample[1] = 0;
      m_ch[0] = 0;
      m_ch[1] = 0;
    end
    ->e_chk;
    #4;
  endtask

  task automatic drive_din(input int addr);
    if (m_cnt >= AP && m_cnt < AP + CW)
      din = logic'((addr >> (CW - 1 - (m_cnt - AP))) & 1);
    else
      din = logic'($urandom_range(0, 1));
  endtask

  function automatic logic [8*DW-1:0] rand_data();
    logic [8*DW-1:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r;
  endfunction

  // frame bits seen on the 8-channel instance are returned MSB-first in bits
  task automatic run_frame(input int addr, input int nclk, input int abort_at,
                           input int rst_at, input int chg_at, output logic [FL-1:0] bits);
    bit stop;
    stop = 0;
    bits = '0;
    set_cs(1'b0);
    drive_din(addr);
    for (int k = 0; k < nclk && !stop; k++) begin
      if (k == abort_at) begin
        set_cs(1'b1);
        chk("abort_oe", int'(bus0.sdata_oe), 0);
        stop = 1;
      end else if (k == rst_at) begin
        set_rst(1'b0);
        chk("rst_mid_sdata", int'(sd0), 0);
        chk("rst_mid_oe", int'(bus0.sdata_oe), 1);
        chk("rst_mid_ch", int'(bus0.cur_ch), 0);
        set_cs(1'b1);
        set_rst(1'b1);
        stop = 1;
      end else begin
        if (k == chg_at) ch_data = rand_data();
        if (k < FL) bits[FL-1-k] = sd0;
        neg_step();
        drive_din(addr);
        pos_step();
      end
    end
    if (!stop) begin
      if (nclk >= FL) chk("z_after_frame", int'(bus0.sdata_oe), 0);
      set_cs(1'b1);
    end
  endtask

  initial begin
    logic [FL-1:0] bits;
    int addr;
    int nclk;
    int abort_at;
    int rst_at;
    n_tests = 0;
    n_fail = 0;
    m_cnt = 0;
    m_addr = 0;
    m_ch[0] = 0;
    m_ch[1] = 0;
    m_sample[0] = 0;
    m_sample[1] = 0;
    sclk = 1'b1;
    n_rst = 1'b1;
    cs_n = 1'b0;
    din = 1'b0;
    ch_data = '0;
    #1;
    cs_n = 1'b1;
    set_rst(1'b0);
    chk("reset_cur_ch", int'(bus0.cur_ch), 0);
    chk("reset_oe", int'(bus0.sdata_oe), 0);
    set_rst(1'b1);

    ch_data = rand_data();
    ch_data[0 +: DW] = 12'hABC;
    run_frame(0, FL, -1, -1, -1, bits);
    chk("frame_ch0_bits", int'(bits), 16'h0ABC);
    chk("frame_ch0_cur", int'(bus0.cur_ch), 0);

    run_frame(5, FL, -1, -1, -1, bits);
    chk("addr5_cur", int'(bus0.cur_ch), 5);
    ch_data[5*DW +: DW] = 12'h5A5;
    run_frame(5, FL, -1, -1, -1, bits);
    chk("frame_ch5_bits", int'(bits), 16'h05A5);

    run_frame(3, FL, 7, -1, -1, bits);
    chk("abort_cur", int'(bus0.cur_ch), 5);
    run_frame(5, FL, -1, -1, -1, bits);
    chk("after_abort_bits", int'(bits), 16'h05A5);

    run_frame(2, FL, -1, -1, -1, bits);
    run_frame(7, FL, -1, -1, -1, bits);
    chk("addr7_cur6", int'(bus1.cur_ch), 2);
    chk("addr7_cur8", int'(bus0.cur_ch), 7);
    run_frame(4, FL, -1, -1, -1, bits);
    chk("addr4_cur6", int'(bus1.cur_ch), 4);

    run_frame(1, 20, -1, -1, -1, bits);
    chk("long_frame_cur", int'(bus0.cur_ch), 1);

    run_frame(5, FL, -1, -1, -1, bits);
    run_frame(3, FL, -1, 9, -1, bits);
    ch_data[0 +: DW] = 12'h123;
    run_frame(0, FL, -1, -1, -1, bits);
    chk("post_rst_bits", int'(bits), 16'h0123);

    for (int i = 0; i < 40; i++) begin
      ch_data = rand_data();
      addr = $urandom_range(0, 7);
      nclk = $urandom_range(10, 22);
      abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 15) : -1;
      rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 15) : -1;
      run_frame(addr, nclk, abort_at, rst_at, $urandom_range(0, 19), bits);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
